// File: rtl/spi_ram_master.sv
// SPI mode-0 master for 24-bit-address serial RAMs: READ (03h) / WRITE (02h) with byte streams.
// Optional build macro SPI_RAM_MASTER_STALL_TIMEOUT_EN aborts a write stalled for 256 cycles.
//
// state | meaning
// IDLE  | select high, waiting for start
// CMD   | shifting out the 8-bit command
// ADDR  | shifting out addr[23:0]
// DATA  | read/write data bytes; write waits here on wr_valid at byte boundaries
// TAIL  | spi_clk held low after the last bit, select still low
// DESEL | select high for 2*CLK_DIV cycles, then done
module spi_ram_master #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        write,
   input  logic [23:0] addr,
   input  logic [7:0]  len,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        spi_clk,
   output logic        spi_mosi,
   output logic        spi_select,
   input  logic        spi_miso
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, TAIL, DESEL} state_t;

   localparam logic [8:0] HALF = 9'(CLK_DIV - 1);
   localparam logic [8:0] DES  = 9'(2 * CLK_DIV - 1);

   state_t      state, state_nx;
   logic [8:0]  cnt;
   logic        sclk, sel, write_q, wait_byte, err_pend;
   logic [4:0]  bit_cnt;
   logic [7:0]  byte_cnt, rx;
   logic [31:0] sh;
   logic        stall, take, phase_end, bit_end, last_bit, timeout;
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
   logic [7:0]  stall_cnt;
`endif

   assign wr_ready   = (state == DATA) && write_q && wait_byte;
   assign busy       = (state != IDLE);
   assign spi_clk    = sclk;
   assign spi_select = sel;
   // First bit of a write byte is passed straight through so the handshake cycle doubles as low-phase cycle one.
   assign spi_mosi   = sel ? 1'b0 : (take ? wr_data[7] : sh[31]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      stall     = wr_ready && !wr_valid;
      take      = wr_ready && wr_valid;
      phase_end = (cnt == 9'd0) && !stall;
      bit_end   = phase_end && sclk;
      last_bit  = (bit_cnt == 5'd0);
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
      timeout   = stall && (stall_cnt == 8'hFF);
`else
      timeout   = 1'b0;
`endif
      state_nx  = state;
      case (state)
         IDLE:  if (start && len != 8'd0) state_nx = CMD;
         CMD:   if (bit_end && last_bit) state_nx = ADDR;
         ADDR:  if (bit_end && last_bit) state_nx = DATA;
         DATA:  if (timeout) state_nx = DESEL;
                else if (bit_end && last_bit && byte_cnt == 8'd1) state_nx = TAIL;
         TAIL:  if (phase_end) state_nx = DESEL;
         DESEL: if (phase_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sclk      <= 1'b0;
         sel       <= 1'b1;
         write_q   <= 1'b0;
         wait_byte <= 1'b0;
         err_pend  <= 1'b0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         rx        <= '0;
         sh        <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
         stall_cnt <= '0;
`endif
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (len == 8'd0) begin
                  done <= 1'b1;
                  err  <= 1'b1;
               end else begin
                  write_q   <= write;
                  sh        <= {(write ? 8'h02 : 8'h03), addr};
                  byte_cnt  <= len;
                  bit_cnt   <= 5'd7;
                  cnt       <= HALF;
                  sclk      <= 1'b0;
                  sel       <= 1'b0;
                  wait_byte <= 1'b0;
                  err_pend  <= 1'b0;
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            CMD, ADDR, DATA: begin
               if (timeout) begin
                  sel       <= 1'b1;
                  sclk      <= 1'b0;
                  cnt       <= DES;
                  err_pend  <= 1'b1;
                  wait_byte <= 1'b0;
               end else if (stall) begin
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
                  stall_cnt <= stall_cnt + 8'd1;
`endif
               end else begin
                  if (take) begin
                     sh        <= {wr_data, 24'h0};
                     wait_byte <= 1'b0;
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
                     stall_cnt <= '0;
`endif
                  end
                  if (cnt != 9'd0) begin
                     cnt <= cnt - 9'd1;
                  end else if (!sclk) begin
                     sclk <= 1'b1;
                     cnt  <= HALF;
                     if (state == DATA && !write_q) begin
                        rx <= {rx[6:0], spi_miso};
                        if (last_bit) begin
                           rd_data  <= {rx[6:0], spi_miso};
                           rd_valid <= 1'b1;
                        end
                     end
                  end else begin
                     sclk <= 1'b0;
                     cnt  <= HALF;
                     if (!last_bit) begin
                        bit_cnt <= bit_cnt - 5'd1;
                        sh      <= {sh[30:0], 1'b0};
                     end else if (state == CMD) begin
                        bit_cnt <= 5'd23;
                        sh      <= {sh[30:0], 1'b0};
                     end else begin
                        bit_cnt <= 5'd7;
                        if (state == DATA && byte_cnt != 8'd1) byte_cnt <= byte_cnt - 8'd1;
                        // A write holds the last bit on mosi until the next byte arrives.
                        if (write_q && !(state == DATA && byte_cnt == 8'd1)) wait_byte <= 1'b1;
                        else sh <= {sh[30:0], 1'b0};
                     end
                  end
               end
            end
            TAIL: begin
               if (cnt != 9'd0) cnt <= cnt - 9'd1;
               else begin
                  sel <= 1'b1;
                  cnt <= DES;
               end
            end
            DESEL: begin
               if (cnt != 9'd0) cnt <= cnt - 9'd1;
               else begin
                  done <= 1'b1;
                  err  <= err_pend;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master (CLK_DIV=2) with a behavioural mode-0 SPI RAM slave.
module tb_spi_ram_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, write = 1'b0, wr_valid = 1'b0;
   logic [23:0] addr = '0;
   logic [7:0]  len = '0, wr_data = '0;
   logic        wr_ready, rd_valid, busy, done, err;
   logic [7:0]  rd_data;
   logic        spi_clk, spi_mosi, spi_select, spi_miso;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_ram_master #(.CLK_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .write(write), .addr(addr), .len(len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_select(spi_select), .spi_miso(spi_miso)
   );

   // slave RAM model
   logic [7:0]  mem [0:63];
   logic [7:0]  mq [$];
   int          sbit = 0;
   logic [7:0]  scmd = '0, sin = '0, stmp;
   logic [23:0] saddr = '0;
   logic        miso_r = 1'b0;
   assign spi_miso = miso_r;

   always @(negedge spi_select) begin
      sbit = 0;
      miso_r = 1'b0;
   end

   always @(posedge spi_clk) if (spi_select === 1'b0) begin
      sin = {sin[6:0], spi_mosi};
      if (sbit < 8) scmd = {scmd[6:0], spi_mosi};
      else if (sbit < 32) saddr = {saddr[22:0], spi_mosi};
      sbit++;
      if (sbit % 8 == 0) begin
         mq.push_back(sin);
         if (sbit > 32) begin
            if (scmd == 8'h02) mem[saddr[5:0]] = sin;
            saddr = saddr + 24'd1;
         end
      end
   end

   always @(negedge spi_clk) if (spi_select === 1'b0 && sbit >= 32 && scmd == 8'h03) begin
      stmp = mem[saddr[5:0]];
      miso_r = stmp[3'(7 - ((sbit - 32) % 8))];
   end

   // transaction driver state
   logic [7:0] wq [$];
   logic [7:0] rq [$];
   int   takes, stall_viol;
   logic err_seen, done_seen;

   task automatic run_txn(input logic w, input logic [23:0] a, input logic [7:0] n,
                          input int stall_byte, input int stall_len, input int poke_at,
                          output int cycles);
      int bi, stalled;
      rq.delete(); mq.delete();
      takes = 0; stall_viol = 0; err_seen = 1'b0; done_seen = 1'b0;
      bi = 0; stalled = 0; cycles = 0;
      write = w; addr = a; len = n; start = 1'b1;
      wr_valid = w;
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
      while (!done_seen && cycles < 5000) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start = (cycles == poke_at);
         if (start) begin
            write = 1'b1; addr = 24'h000000; len = 8'd5;
         end
         if (rd_valid) rq.push_back(rd_data);
         if (done) begin
            done_seen = 1'b1;
            err_seen = err;
         end
         wr_valid = w;
         wr_data = (bi < wq.size()) ? wq[bi] : 8'h00;
         if (wr_ready) begin
            if (bi == stall_byte && stalled < stall_len) begin
               wr_valid = 1'b0;
               stalled++;
               if (spi_clk !== 1'b0 || spi_select !== 1'b0) stall_viol++;
            end else if (w) begin
               takes++;
               bi++;
            end
         end
      end
      start = 1'b0;
      wr_valid = 1'b0;
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", cycles);
      end
   endtask

   task automatic check_mosi(input string name, input logic [7:0] exp [$]);
      checks++;
      if (mq.size() != exp.size()) begin
         errors++;
         $display("FAIL %s_len: got %0d bytes, expected %0d", name, mq.size(), exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (mq[i] !== exp[i]) begin
               errors++;
               $display("FAIL %s_byte%0d: got %h expected %h", name, i, mq[i], exp[i]);
            end
         end
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_int("rst_select", int'(spi_select), 1);
      check_int("rst_sclk",   int'(spi_clk), 0);
      check_int("rst_mosi",   int'(spi_mosi), 0);
      check_int("rst_busy",   int'(busy), 0);
      check_int("rst_done",   int'(done), 0);
      check_int("rst_err",    int'(err), 0);
      check_int("rst_rdv",    int'(rd_valid), 0);
      check_int("rst_wrrdy",  int'(wr_ready), 0);
      check_int("rst_rdata",  int'(rd_data), 0);
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      int cyc;
      logic [7:0] exp [$];
      mem[16] = 8'hA5; mem[17] = 8'h3C;
      wq.delete();
      run_txn(1'b0, 24'h000010, 8'd2, -1, 0, 50, cyc);
      check_int("read_done_cycle", cyc, 199);
      check_int("read_count", rq.size(), 2);
      if (rq.size() == 2) begin
         check_int("read_byte0", int'(rq[0]), 8'hA5);
         check_int("read_byte1", int'(rq[1]), 8'h3C);
      end
      check_int("read_err", int'(err_seen), 0);
      exp = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      check_mosi("read_mosi", exp);
      check_int("read_select_end", int'(spi_select), 1);
      check_int("read_busy_end", int'(busy), 0);
   endtask

   task automatic test_write_single();
      int cyc;
      logic [7:0] exp [$];
      mem[4] = 8'h00;
      wq = '{8'h81};
      run_txn(1'b1, 24'h000004, 8'd1, -1, 0, -1, cyc);
      check_int("wr1_done_cycle", cyc, 167);
      check_int("wr1_ready_pulses", takes, 1);
      check_int("wr1_mem4", int'(mem[4]), 8'h81);
      exp = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h81};
      check_mosi("wr1_mosi", exp);
   endtask

   task automatic test_write_stall();
      int cyc;
      logic [7:0] exp [$];
      mem[8] = 8'h00; mem[9] = 8'h00; mem[10] = 8'h00;
      wq = '{8'h11, 8'h22, 8'h33};
      run_txn(1'b1, 24'h000008, 8'd3, 1, 50, -1, cyc);
      check_int("stall_done_cycle", cyc, 281);
      check_int("stall_sclk_select_low", stall_viol, 0);
      check_int("stall_takes", takes, 3);
      check_int("stall_mem8", int'(mem[8]), 8'h11);
      check_int("stall_mem9", int'(mem[9]), 8'h22);
      check_int("stall_mem10", int'(mem[10]), 8'h33);
      check_int("stall_err", int'(err_seen), 0);
      exp = '{8'h02, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33};
      check_mosi("stall_mosi", exp);
   endtask

   task automatic test_reset_mid();
      int cyc;
      write = 1'b0; addr = 24'h000010; len = 8'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (114) @(posedge clk);
      #2;
      check_int("mid_pre_sclk", int'(spi_clk), 1);
      check_int("mid_pre_select", int'(spi_select), 0);
      rst_n = 1'b0;
      #1;
      check_int("mid_async_sclk", int'(spi_clk), 0);
      check_int("mid_async_select", int'(spi_select), 1);
      check_int("mid_async_busy", int'(busy), 0);
      check_int("mid_async_mosi", int'(spi_mosi), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem[16] = 8'h5A; mem[17] = 8'hC3;
      wq.delete();
      run_txn(1'b0, 24'h000010, 8'd2, -1, 0, -1, cyc);
      check_int("mid_read_cycle", cyc, 199);
      check_int("mid_read_count", rq.size(), 2);
      if (rq.size() == 2) begin
         check_int("mid_read_byte0", int'(rq[0]), 8'h5A);
         check_int("mid_read_byte1", int'(rq[1]), 8'hC3);
      end
   endtask

   task automatic test_len0();
      write = 1'b0; addr = 24'h000010; len = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_int("len0_err", int'(err), 1);
      check_int("len0_done", int'(done), 1);
      check_int("len0_busy", int'(busy), 0);
      check_int("len0_select", int'(spi_select), 1);
      @(negedge clk);
      check_int("len0_err_pulse", int'(err), 0);
      check_int("len0_done_pulse", int'(done), 0);
      check_int("len0_select_after", int'(spi_select), 1);
   endtask

`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
   task automatic test_stall_timeout();
      int cyc;
      wq = '{8'hEE};
      run_txn(1'b1, 24'h000020, 8'd1, 0, 1000000, -1, cyc);
      check_int("tmo_done_cycle", cyc, 389);
      check_int("tmo_err", int'(err_seen), 1);
      check_int("tmo_select", int'(spi_select), 1);
      check_int("tmo_busy", int'(busy), 0);
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      test_reset();
      @(negedge clk);
      test_read();
      @(negedge clk);
      test_write_single();
      @(negedge clk);
      test_write_stall();
      @(negedge clk);
      test_len0();
      test_reset_mid();
`ifdef SPI_RAM_MASTER_STALL_TIMEOUT_EN
      @(negedge clk);
      test_stall_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
